// File: rtl/pmm_stream_nx.sv
// pmm_stream_nx
// Multi-channel bit-parallel NFA matcher (shift-and with self-loops and
// epsilon blocks). Interleaved characters from NUM_CH channels share one
// programmable table set. Each channel keeps its own NFA state, position
// counter and match counter.
//
// Two stages:
//   s1     : channel is registered and SELFLOOP/MOVE are read (sync RAM).
//   stage 2: the NFA update for that channel is computed and written into
//            the output register.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   command handshake
//   in_op            00 nop, 01 config write, 10 character, 11 channel reset
//   in_ch            channel for ops 10/11 (out-of-range commands are dropped)
//   in_addr/in_data  config address/word, or the character in in_data[CHAR_W-1:0]
//   out_valid/ready  result beat handshake
//   out_ch           channel of the beat
//   out_match        new state intersects ACCEPT
//   out_pos          0-based position of the character within its channel
//   out_cnt          channel match count including this beat
module pmm_stream_nx #(
    parameter int STATE_W = 64,
    parameter int CHAR_W  = 8,
    parameter int NUM_CH  = 4,
    parameter int POS_W   = 16,
    parameter int CNT_W   = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ADDR_W = CHAR_W + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_match,
    output logic [POS_W-1:0]   out_pos,
    output logic [CNT_W-1:0]   out_cnt
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_CFG  = 2'b01,
        OP_CHAR = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    localparam int TBL_D = 2 ** CHAR_W;

    // Table storage and stage-1 read data.
    logic [STATE_W-1:0] selfloop_q [TBL_D];
    logic [STATE_W-1:0] move_q     [TBL_D];
    logic [STATE_W-1:0] s1_sl_q, s1_mv_q;

    // Control words.
    logic [STATE_W-1:0] eps_beg_q, eps_blk_q, eps_end_q, init_q, accept_q;

    // Per-channel context.
    logic [STATE_W-1:0] state_q [NUM_CH];
    logic [POS_W-1:0]   pos_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];

    // Pipeline registers.
    logic               s1_valid_q;
    logic [CH_W-1:0]    s1_ch_q;
    logic               out_valid_q, out_match_q;
    logic [CH_W-1:0]    out_ch_q;
    logic [POS_W-1:0]   out_pos_q;
    logic [CNT_W-1:0]   out_cnt_q;

    op_e                op;
    logic               adv, accept, ch_ok;
    logic               char_acc, cfg_acc, clr_acc;
    logic [1:0]         cfg_region;
    logic [CHAR_W-1:0]  cfg_idx, in_char;

    assign op         = op_e'(in_op);
    assign adv        = s1_valid_q && (!out_valid_q || out_ready);
    assign ch_ok      = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
    assign cfg_region = in_addr[ADDR_W-1 -: 2];
    assign cfg_idx    = in_addr[CHAR_W-1:0];
    assign in_char    = in_data[CHAR_W-1:0];

    // Config writes and channel resets wait for an empty s1 so that every
    // character accepted afterwards observes the new value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        in_ready = !s1_valid_q || adv;
        if (op == OP_CFG || op == OP_CLR) begin
            in_ready = !s1_valid_q;
        end
    end

    assign accept   = in_valid && in_ready;
    assign char_acc = accept && (op == OP_CHAR) && ch_ok;
    assign cfg_acc  = accept && (op == OP_CFG);
    assign clr_acc  = accept && (op == OP_CLR) && ch_ok;

    // NOTE: the tables are plain RAMs with no reset; only the control words and channel context are reset.
    always_ff @(posedge clk) begin
        if (cfg_acc && cfg_region == 2'b00) selfloop_q[cfg_idx] <= in_data;
        if (cfg_acc && cfg_region == 2'b01) move_q[cfg_idx]     <= in_data;
        if (char_acc) begin
            s1_sl_q <= selfloop_q[in_char];
            s1_mv_q <= move_q[in_char];
        end
    end

    // Stage 2: NFA step for the channel held in s1.
    logic [STATE_W-1:0] cur_s, tmp, high, low, state_d;
    logic [POS_W-1:0]   pos_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               hit;

    always_comb begin
        cur_s   = state_q[s1_ch_q];
        tmp     = (((cur_s << 1) | init_q) & s1_mv_q) | (cur_s & s1_sl_q);
        high    = tmp | eps_end_q;
        low     = high - eps_beg_q;
        // Bits of an epsilon block fill in from its lowest active bit up to
        // the block end; the subtraction borrow marks that span.
        state_d = (eps_blk_q & (~low ^ high)) | tmp;
        hit     = |(state_d & accept_q);
        pos_d   = pos_q[s1_ch_q] + POS_W'(1);
        cnt_d   = cnt_q[s1_ch_q];
        if (hit && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            eps_beg_q   <= '0;
            eps_blk_q   <= '0;
            eps_end_q   <= '0;
            init_q      <= '0;
            accept_q    <= '0;
            out_valid_q <= 1'b0;
            out_match_q <= 1'b0;
            out_ch_q    <= '0;
            out_pos_q   <= '0;
            out_cnt_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= '0;
                pos_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            if (char_acc) begin
                s1_valid_q <= 1'b1;
                s1_ch_q    <= in_ch;
            end else if (adv) begin
                s1_valid_q <= 1'b0;
            end

            if (cfg_acc && cfg_region == 2'b10) begin
                case (cfg_idx)
                    CHAR_W'(0): eps_beg_q <= in_data;
                    CHAR_W'(1): eps_blk_q <= in_data;
                    CHAR_W'(2): eps_end_q <= in_data;
                    CHAR_W'(3): init_q    <= in_data;
                    CHAR_W'(4): accept_q  <= in_data;
                    default: ;
                endcase
            end

            // Cannot collide with the stage-2 update: op 11 needs an empty s1.
            if (clr_acc) begin
                state_q[in_ch] <= '0;
                pos_q[in_ch]   <= '0;
            end

            if (adv) begin
                state_q[s1_ch_q] <= state_d;
                pos_q[s1_ch_q]   <= pos_d;
                cnt_q[s1_ch_q]   <= cnt_d;
                out_valid_q      <= 1'b1;
                out_ch_q         <= s1_ch_q;
                out_match_q      <= hit;
                out_pos_q        <= pos_q[s1_ch_q];
                out_cnt_q        <= cnt_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_match = out_match_q;
    assign out_pos   = out_pos_q;
    assign out_cnt   = out_cnt_q;

endmodule
